// File: rtl/wb_pwm.sv
// Wishbone B4 classic responder driving up to four PWM outputs from a shared
// prescaled counter; period and duty are double-buffered and reload only at wrap.
module wb_pwm #(
    parameter int channels  = 4,
    parameter int cnt_width = 16
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic [4:0]          wb_adr,
    input  logic [31:0]         wb_dat,
    input  logic [3:0]          wb_sel,
    input  logic                wb_we,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    output logic [31:0]         wb_rdt,
    output logic                wb_ack,
    output logic [channels-1:0] pwm_out
);

    localparam int CW   = cnt_width;
    localparam int PADW = 32 - cnt_width;

    logic [channels-1:0] r_en;
    logic                r_run;
    logic [CW-1:0]       r_prescale;
    logic [CW-1:0]       r_period;
    logic [CW-1:0]       r_duty    [channels];
    logic [CW-1:0]       r_period_sh;
    logic [CW-1:0]       r_duty_sh [channels];
    logic [CW-1:0]       r_pre;
    logic [CW-1:0]       r_cnt;
    logic [channels-1:0] r_pwm;
    logic                r_ack;
    logic [31:0]         r_rdt;

    logic                w_req;
    logic                w_wr;
    logic                w_tick;
    logic                w_wrap;
    logic                w_clr;
    logic [31:0]         w_ctrl32;
    logic [31:0]         w_rd_mux;
    logic [channels-1:0] w_duty_wr;
    logic                w_unused;

    function automatic logic [31:0] f_zext(input logic [CW-1:0] v);
        return {{PADW{1'b0}}, v};
    endfunction

    // Byte-lane merge of a bus write into a cnt_width-wide field.
    function automatic logic [CW-1:0] f_wr_field(input logic [CW-1:0] old,
                                                 input logic [31:0]   dat,
                                                 input logic [3:0]    sel);
        logic [CW-1:0] res;
        for (int j = 0; j < CW; j++) begin
            res[j] = sel[j / 8] ? dat[j] : old[j];
        end
        return res;
    endfunction

    assign w_req    = wb_cyc & wb_stb & ~r_ack;
    assign w_wr     = w_req & wb_we;
    assign w_tick   = r_run & (r_pre == r_prescale);
    assign w_wrap   = w_tick & (r_cnt == r_period_sh);
    assign w_clr    = w_wr & (wb_adr[4:2] == 3'd0) & wb_sel[1] & wb_dat[9];
    assign w_ctrl32 = {23'b0, r_run, {(8 - channels){1'b0}}, r_en};
    assign w_unused = &{1'b0, wb_adr[1:0], wb_dat, wb_sel};

    always_comb begin
        w_rd_mux  = '0;
        w_duty_wr = '0;
        case (wb_adr[4:2])
            3'd0:    w_rd_mux = w_ctrl32;
            3'd1:    w_rd_mux = f_zext(r_prescale);
            3'd2:    w_rd_mux = f_zext(r_period);
            3'd3:    w_rd_mux = f_zext(r_cnt);
            default: begin
                for (int i = 0; i < channels; i++) begin
                    if (wb_adr[4:2] == 3'(i + 4)) begin
                        w_rd_mux = f_zext(r_duty[i]);
                    end
                end
            end
        endcase
        for (int i = 0; i < channels; i++) begin
            w_duty_wr[i] = w_wr & (wb_adr[4:2] == 3'(i + 4));
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_en        <= '0;
            r_run       <= 1'b0;
            r_prescale  <= '0;
            r_period    <= '0;
            r_period_sh <= '0;
            r_pre       <= '0;
            r_cnt       <= '0;
            r_pwm       <= '0;
            r_ack       <= 1'b0;
            r_rdt       <= '0;
            for (int i = 0; i < channels; i++) begin
                r_duty[i]    <= '0;
                r_duty_sh[i] <= '0;
            end
        end else begin
            r_ack <= w_req;
            r_rdt <= w_req ? w_rd_mux : 32'd0;

            if (w_wr) begin
                case (wb_adr[4:2])
                    3'd0: begin
                        if (wb_sel[0]) r_en  <= wb_dat[channels-1:0];
                        if (wb_sel[1]) r_run <= wb_dat[8];
                    end
                    3'd1:    r_prescale <= f_wr_field(r_prescale, wb_dat, wb_sel);
                    3'd2:    r_period   <= f_wr_field(r_period, wb_dat, wb_sel);
                    default: ;
                endcase
            end
            for (int i = 0; i < channels; i++) begin
                if (w_duty_wr[i]) r_duty[i] <= f_wr_field(r_duty[i], wb_dat, wb_sel);
            end

            // CLR overrides any tick in the same cycle; shadows sample the old register values.
            if (w_clr) begin
                r_pre       <= '0;
                r_cnt       <= '0;
                r_period_sh <= r_period;
                for (int i = 0; i < channels; i++) r_duty_sh[i] <= r_duty[i];
            end else if (r_run) begin
                if (w_tick) begin
                    r_pre <= '0;
                    if (w_wrap) begin
                        r_cnt       <= '0;
                        r_period_sh <= r_period;
                        for (int i = 0; i < channels; i++) r_duty_sh[i] <= r_duty[i];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end else begin
                r_period_sh <= r_period;
                for (int i = 0; i < channels; i++) r_duty_sh[i] <= r_duty[i];
            end

            for (int i = 0; i < channels; i++) begin
                r_pwm[i] <= r_run & r_en[i] & (r_cnt < r_duty_sh[i]);
            end
        end
    end

    assign wb_ack  = r_ack;
    assign wb_rdt  = r_rdt;
    assign pwm_out = r_pwm;

endmodule

// File: tb/tb_wb_pwm.sv
// Scoreboarded bench for wb_pwm: register access, byte lanes, PWM waveforms,
// shadow reload timing and Wishbone handshake behaviour.
module tb_wb_pwm;

    localparam int CH = 3;
    localparam int CW = 16;

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b1;
    logic [4:0]    wb_adr = '0;
    logic [31:0]   wb_dat = '0;
    logic [3:0]    wb_sel = '0;
    logic          wb_we  = 1'b0;
    logic          wb_cyc = 1'b0;
    logic          wb_stb = 1'b0;
    logic [31:0]   wb_rdt;
    logic          wb_ack;
    logic [CH-1:0] pwm_out;

    int            n_chk   = 0;
    int            n_err   = 0;
    int            rdt_bad = 0;
    logic [31:0]   sb_q[$];
    logic [CH-1:0] smp[64];

    wb_pwm #(.channels(CH), .cnt_width(CW)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .wb_adr (wb_adr),
        .wb_dat (wb_dat),
        .wb_sel (wb_sel),
        .wb_we  (wb_we),
        .wb_cyc (wb_cyc),
        .wb_stb (wb_stb),
        .wb_rdt (wb_rdt),
        .wb_ack (wb_ack),
        .pwm_out(pwm_out)
    );

    always #5 wb_clk = ~wb_clk;

    always @(negedge wb_clk) begin
        if (!wb_rst && wb_ack === 1'b0 && wb_rdt !== 32'd0) rdt_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input string tag);
        int t = 0;
        wb_we  = we;
        wb_adr = adr;
        wb_dat = dat;
        wb_sel = sel;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        do begin
            @(posedge wb_clk);
            #1;
            t++;
        end while (!wb_ack && t < 20);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        chk({tag, "_ack"}, {31'b0, wb_ack}, 32'd1);
        if (!we && sb_q.size() > 0) chk(tag, wb_rdt, sb_q.pop_front());
    endtask

    task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_xfer(1'b1, adr, dat, sel, "wr");
    endtask

    task automatic wb_read(input logic [4:0] adr, input logic [31:0] exp, input string tag);
        sb_q.push_back(exp);
        wb_xfer(1'b0, adr, 32'd0, 4'hF, tag);
    endtask

    task automatic sample(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wb_clk);
            smp[i] = pwm_out;
        end
    endtask

    function automatic int cnt_hi(input int ch, input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) c += int'(smp[k][ch]);
        return c;
    endfunction

    // Distance between the first two rising edges of a channel in the sample buffer.
    function automatic int rise_gap(input int ch, input int n);
        int r1 = -1;
        int r2 = -1;
        for (int k = 1; k < n; k++) begin
            if (smp[k][ch] && !smp[k-1][ch]) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
        end
        return (r1 < 0 || r2 < 0) ? -1 : r2 - r1;
    endfunction

    task automatic wait_rise0(input string tag);
        logic prev  = 1'b1;
        logic found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge wb_clk);
            if (pwm_out[0] && !prev) found = 1'b1;
            prev = pwm_out[0];
        end
        chk(tag, {31'b0, found}, 32'd1);
    endtask

    initial begin
        logic [5:0] pat;

        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 1'b0;
        chk("rst_ack", {31'b0, wb_ack}, 32'd0);
        chk("rst_pwm", {29'b0, pwm_out}, 32'd0);
        chk("rst_rdt", wb_rdt, 32'd0);
        for (int a = 0; a < 7; a++) wb_read(5'(a * 4), 32'd0, "rst_reg");
        wb_read(5'h1C, 32'd0, "unmapped_duty3");

        // Byte lanes, read-only and unmapped writes
        wb_write(5'h08, 32'h0000ABCD, 4'b0001);
        wb_read(5'h08, 32'h000000CD, "period_lane0");
        wb_write(5'h08, 32'h00001234, 4'b0010);
        wb_read(5'h08, 32'h000012CD, "period_lane1");
        wb_write(5'h0C, 32'h0000FFFF, 4'hF);
        wb_read(5'h0C, 32'd0, "cnt_ro");
        wb_write(5'h1C, 32'h0000FFFF, 4'hF);
        wb_read(5'h1C, 32'd0, "unmapped_wr");
        wb_write(5'h00, 32'hFFFFFEFF, 4'b0001);
        wb_read(5'h00, 32'h00000007, "ctrl_en_mask");
        wb_write(5'h00, 32'h00000000, 4'b0001);

        // Basic PWM with output limits
        wb_write(5'h04, 32'd0, 4'hF);
        wb_write(5'h08, 32'd9, 4'hF);
        wb_write(5'h10, 32'd3, 4'hF);
        wb_write(5'h14, 32'd0, 4'hF);
        wb_write(5'h18, 32'd12, 4'hF);
        wb_write(5'h00, 32'h00000200, 4'b0010);
        wb_write(5'h00, 32'h00000107, 4'b0011);
        repeat (5) @(negedge wb_clk);
        sample(30);
        chk("basic_hi20", 32'(cnt_hi(0, 0, 19)), 32'd6);
        chk("basic_gap", 32'(rise_gap(0, 30)), 32'd10);
        chk("duty0_low", 32'(cnt_hi(1, 0, 19)), 32'd0);
        chk("duty_gt_per_high", 32'(cnt_hi(2, 0, 19)), 32'd20);

        wb_write(5'h00, 32'h00000106, 4'b0011);
        repeat (2) @(negedge wb_clk);
        sample(20);
        chk("en_off_low", 32'(cnt_hi(0, 0, 19)), 32'd0);
        chk("en_on_high", 32'(cnt_hi(2, 0, 19)), 32'd20);
        wb_write(5'h00, 32'h00000107, 4'b0011);

        // Mid-period duty change takes effect from the next period
        wait_rise0("rise_mid");
        fork
            wb_write(5'h10, 32'd7, 4'hF);
            sample(24);
        join
        chk("shadow_cur", 32'(cnt_hi(0, 0, 8)), 32'd2);
        chk("shadow_next", 32'(cnt_hi(0, 9, 18)), 32'd7);

        // Write landing on the wrap edge is deferred a full period
        wait_rise0("rise_wrap");
        repeat (8) @(negedge wb_clk);
        fork
            wb_write(5'h10, 32'd3, 4'hF);
            sample(24);
        join
        chk("wrap_kept", 32'(cnt_hi(0, 0, 9)), 32'd7);
        chk("wrap_later", 32'(cnt_hi(0, 10, 19)), 32'd3);

        // Stop, then clear
        wb_write(5'h00, 32'h00000007, 4'b0011);
        repeat (2) @(negedge wb_clk);
        sample(20);
        chk("stop_low", {29'b0, smp[0] | smp[10] | smp[19]}, 32'd0);
        wb_write(5'h00, 32'h00000207, 4'b0011);
        wb_read(5'h0C, 32'd0, "clr_cnt");
        wb_read(5'h00, 32'h00000007, "clr_reads0");

        // Prescaler stretches the period
        wb_write(5'h04, 32'd1, 4'hF);
        wb_write(5'h00, 32'h00000107, 4'b0011);
        repeat (4) @(negedge wb_clk);
        sample(50);
        chk("pre_gap", 32'(rise_gap(0, 50)), 32'd20);
        chk("pre_hi20", 32'(cnt_hi(0, 0, 19)), 32'd6);
        wb_write(5'h00, 32'h00000007, 4'b0011);

        // Held request: one ack every other cycle
        @(posedge wb_clk);
        #1;
        repeat (3) sb_q.push_back(32'd9);
        pat    = '0;
        wb_we  = 1'b0;
        wb_adr = 5'h08;
        wb_sel = 4'hF;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk);
            #1;
            pat = {pat[4:0], wb_ack};
            if (wb_ack && sb_q.size() > 0) chk("hs_rdt", wb_rdt, sb_q.pop_front());
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        chk("hs_pattern", {26'b0, pat}, 32'h2A);
        chk("hs_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset while a request is pending
        @(posedge wb_clk);
        #1;
        pat    = '0;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge wb_clk);
            #1;
            pat = {pat[4:0], wb_ack};
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_rst = 1'b0;
        @(posedge wb_clk);
        #1;
        pat = {pat[4:0], wb_ack};
        chk("rst_drop_ack", {26'b0, pat}, 32'd0);
        wb_read(5'h08, 32'd0, "rst2_period");
        wb_read(5'h00, 32'd0, "rst2_ctrl");

        chk("rdt_idle", 32'(rdt_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_pwm.md
# wb_pwm

Wishbone B4 classic responder providing a multi-channel PWM generator for motor and servo drive. It sits on the CPU-side Wishbone bus driven by the serv core/arbiter, decoded by the system interconnect, and responds to 32-bit word accesses with a registered single-cycle acknowledge. Duty and period registers are double-buffered and reload only at period wrap, so that outputs never glitch mid-period.

## Interface
- `channels`, 4: number of PWM outputs, 1..4.
- `cnt_width`, 16: width of the prescaler, period, counter and duty fields, 8..16.
- `wb_clk`  in  1  sole clock.
- `wb_rst`  in  1  synchronous, active-high reset.
- `wb_adr`  in  5  byte address, bits [4:2] select the register and bits [1:0] are ignored.
- `wb_dat`  in  32  write data.
- `wb_sel`  in  4  byte enables, honoured per byte on writes.
- `wb_we`  in  1  write enable.
- `wb_cyc`  in  1  bus cycle.
- `wb_stb`  in  1  strobe.
- `wb_rdt`  out  32  read data, valid while `wb_ack`=1.
- `wb_ack`  out  1  acknowledge.
- `pwm_out`  out  `channels`  PWM outputs, registered.

## Operation
- Register map:
  - 0x00 CTRL:
    - [channels-1:0] EN, per-channel enable.
    - [8] RUN.
    - [9] CLR, write-1 self-clearing; it always reads as 0.
  - 0x04 PRESCALE [cnt_width-1:0]: one counter tick every PRESCALE+1 clocks.
  - 0x08 PERIOD [cnt_width-1:0]: the counter counts 0..PERIOD inclusive, then wraps.
  - 0x0C CNT: read-only current counter value; writes are ignored.
  - 0x10/0x14/0x18/0x1C DUTY0..3 [cnt_width-1:0]. A DUTYn with n ≥ `channels` is unmapped.
- Unmapped and reserved bits read 0. Writes to them are ignored.
- Every access is acknowledged, including unmapped ones. The bus never sees an error or stall.
- Reset: all registers, shadows, prescaler, counter, `pwm_out`, `wb_ack` and `wb_rdt` go to 0.
- Prescaler `pre`:
  - While RUN=1: when `pre`==PRESCALE, `tick`=1 and `pre` goes to 0; otherwise `pre` increments.
  - While RUN=0: `pre` and `cnt` hold.
- Counter, on a tick:
  - If `cnt`==`period_sh`, then `cnt` goes to 0 (wrap) and the shadows load.
  - Otherwise `cnt` increments.
- Shadows (`period_sh`, `duty_sh[i]`):
  - While RUN=0, they copy their registers every cycle.
  - While RUN=1, they load only at wrap.
  - A register written in the same cycle as a wrap is not captured; the shadow keeps the old value until the next wrap.
- CLR write: on the next cycle `pre` and `cnt` go to 0 and all shadows load. CLR takes precedence over a simultaneous tick.
- Output: `pwm_out[i]` <= RUN & EN[i] & (`cnt` < `duty_sh[i]`), compared unsigned at `cnt_width` bits.
  - DUTY=0 gives a constant low output.
  - DUTY > PERIOD gives a constant high output.
  - The resulting duty fraction is DUTY/(PERIOD+1).
- Wishbone handshake:
  - Request = `wb_cyc` & `wb_stb` & ~`wb_ack`.
  - The register write and read-data capture happen on the clock edge where the request is seen.
  - `wb_ack`=1 for exactly the next cycle, then returns to 0.
- Back-to-back requests: the next access is accepted in the cycle after the ack, so the minimum spacing is 2 cycles per access.
- Write-to-read ordering: a read returns register contents as updated by all earlier acknowledged writes.
- `wb_rdt`: 0 whenever `wb_ack`=0.
- Reset mid-transaction: the pending ack is dropped, and the initiator's cycle never completes until it re-issues.

## Timing
- Access latency: request at cycle T gives `wb_ack`/`wb_rdt` at T+1.
- Write effects:
  - A register written at T reads back at T+1.
  - With RUN=0, the matching shadow updates at T+2.
- CNT read value: `cnt` as sampled at edge T.
- `pwm_out` lags `cnt` by one cycle because it is registered.
- Period length: (PERIOD+1)·(PRESCALE+1) clocks.
- Start: a RUN 0→1 write at T gives the first tick at T+1+PRESCALE, counting from `cnt`=0 only if the counter was cleared.
- Stop: RUN 1→0 holds `cnt` and drives `pwm_out` to 0 on the following cycle.

## Test plan
- Reset → `wb_ack`=0, `pwm_out`=0, and every mapped register reads 0x00000000.
- Byte lanes: write PERIOD=0xABCD with `wb_sel`=4'b0001, then read → 0x000000CD.
  - Also check that an unmapped read at 0x1C with `channels`=3 returns 0 and is acked.
- Basic PWM: PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=0x101 → `pwm_out[0]` high for 3 of every 10 clocks, steadily.
- Output limits: DUTY1=0 gives constant low; DUTY2=12 with PERIOD=9 gives constant high.
  - With EN bit clear, the output stays 0.
- Shadowing: with the generator running, write DUTY0=7 mid-period.
  - The current period keeps a 3-clock high time.
  - The next period is 7 clocks high.
  - Also write DUTY0 exactly in the wrap cycle and check the change is delayed one full period.
- Handshake: hold `wb_cyc`/`wb_stb` for 6 cycles → exactly 3 single-cycle acks, on alternating cycles.
  - Also assert `wb_rst` while a request is pending → no ack is issued.
